mac_seq_ctrl: RTL
=================

Name: mac_seq_ctrl

Overview:
- Sequencer for one MAC datapath lane. It computes one unsigned dot-product of cmd_len element pairs per command.
- Accepts a length command and streams operand pairs into the MAC with a valid/ready handshake.
- Holds the running accumulator, which it feeds back to the MAC as its accumulate input.
- Retires the MAC's one-cycle-delayed results and presents the final sum on a result handshake.

Parameters:
DATA_SIZE, 8, operand width in bits
OUTPUT_BUF_SIZE, 32, accumulator/result width in bits
LEN_W, 8, width of the element-count field

Ports:
clk_i  in  1  clock
rst_i  in  1  reset: one clock; reset is asynchronous and active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready (IDLE only)
cmd_len_i  in  LEN_W  number of element pairs
op_valid_i  in  1  operand pair valid
op_ready_o  out  1  operand pair ready
op_a_i  in  DATA_SIZE  operand A
op_b_i  in  DATA_SIZE  operand B
mac_in1_o  out  DATA_SIZE  to MAC in1
mac_in2_o  out  DATA_SIZE  to MAC in2
mac_valid_o  out  1  to MAC valid
mac_chunk_end_o  out  1  to MAC chunk_end, high with last issued pair
mac_acc_o  out  OUTPUT_BUF_SIZE  accumulator fed to MAC acc input
mac_acc_val_i  in  1  MAC product-valid (one cycle after mac_valid_o)
mac_acc_i  in  OUTPUT_BUF_SIZE  MAC sum output (mac_acc_o + product)
res_valid_o  out  1  result valid
res_ready_i  in  1  result ready
res_dat_o  out  OUTPUT_BUF_SIZE  dot-product result
busy_o  out  1  high in any state except IDLE

Behaviour:
- **States:** IDLE, RUN, DRAIN, DONE.
- **Reset:** rst_i low asynchronously forces the following, regardless of current state:
  - state=IDLE;
  - len_r, issued_r, retired_r and acc_r all cleared to 0;
  - all outputs 0, except cmd_ready_o=1.
- **IDLE:**
  - cmd_ready_o=1.
  - On cmd_valid_i: latch len_r=cmd_len_i, clear acc_r/issued_r/retired_r.
  - If cmd_len_i==0, go to DONE (result 0); otherwise go to RUN.
- **RUN:**
  - op_ready_o=(issued_r<len_r).
  - Fire = op_valid_i & op_ready_o.
  - mac_valid_o=fire (combinational); mac_in1_o=op_a_i, mac_in2_o=op_b_i; these are driven 0 when not firing.
  - Each fire increments issued_r.
  - mac_chunk_end_o=fire & (issued_r==len_r-1).
  - After the last fire, go to DRAIN.
- **Retire (RUN or DRAIN):**
  - When mac_acc_val_i=1: acc_r<=mac_acc_i and retired_r++.
  - mac_acc_o=acc_r at all times.
  - The MAC adds acc_r combinationally in the cycle its product is valid. Back-to-back fires therefore accumulate correctly at one element per cycle.
- **DRAIN:**
  - op_ready_o=0.
  - Leave for DONE in the cycle after retired_r reaches len_r, so that acc_r holds the final sum.
- **DONE:**
  - res_valid_o=1, res_dat_o=acc_r, both held stable until res_ready_i.
  - On handshake, go to IDLE.
  - No new command is accepted until IDLE.
- **Arithmetic:**
  - Operands are unsigned.
  - Product width is 2*DATA_SIZE, zero-extended.
  - Sum wraps modulo 2^OUTPUT_BUF_SIZE; there is no saturation and no overflow flag.
- **Throughput and latency:**
  - One pair per cycle when op_valid_i is continuous.
  - Latency from last fire to res_valid_o is 2 cycles.
- **Stalls:**
  - op_valid_i gaps simply pause issuing.
  - Retirement never stalls.
- **Error tolerance:** mac_acc_val_i asserted in IDLE or DONE is ignored and does not modify acc_r.
- **Reset mid-operation:**
  - Products still in flight in the MAC are discarded by the IDLE rule above.
  - The MAC instance is reset by the same top-level reset tree.

Test Plan:
- Reset then idle → cmd_ready_o=1, busy_o=0, res_valid_o=0, op_ready_o=0.
- cmd_len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back → mac_valid_o high 4 consecutive cycles, mac_chunk_end_o on the 4th only, res_dat_o=100 two cycles after the last fire.
- cmd_len=3, pairs (255,255)×3 with a 2-cycle op_valid_i gap between the 1st and 2nd → res_dat_o=195075, no extra fires.
- cmd_len=0 → DONE the next cycle, res_dat_o=0, no mac_valid_o pulse.
- OUTPUT_BUF_SIZE=16, cmd_len=2, pairs (255,255),(255,255) → res_dat_o=130050 mod 65536=64514.
- Result back-pressure: hold res_ready_i=0 for 5 cycles → res_valid_o and res_dat_o stable, cmd_ready_o=0. Then rst_i low during RUN of a cmd_len=4 run after 2 fires → all outputs reach reset values immediately. After release, a new cmd_len=1 with pair (2,3) returns 6.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// Handshake and MAC-side bundle for one mac_seq_ctrl lane.
// slave is the sequencer side, master is the command/operand/MAC side.
interface mac_seq_ctrl_if #(
  parameter int DATA_SIZE       = 8,
  parameter int OUTPUT_BUF_SIZE = 32,
  parameter int LEN_W           = 8
);
  logic                       cmd_valid_i;
  logic                       cmd_ready_o;
  logic [LEN_W-1:0]           cmd_len_i;
  logic                       op_valid_i;
  logic                       op_ready_o;
  logic [DATA_SIZE-1:0]       op_a_i;
  logic [DATA_SIZE-1:0]       op_b_i;
  logic [DATA_SIZE-1:0]       mac_in1_o;
  logic [DATA_SIZE-1:0]       mac_in2_o;
  logic                       mac_valid_o;
  logic                       mac_chunk_end_o;
  logic [OUTPUT_BUF_SIZE-1:0] mac_acc_o;
  logic                       mac_acc_val_i;
  logic [OUTPUT_BUF_SIZE-1:0] mac_acc_i;
  logic                       res_valid_o;
  logic                       res_ready_i;
  logic [OUTPUT_BUF_SIZE-1:0] res_dat_o;
  logic                       busy_o;

  modport slave (
    input  cmd_valid_i, cmd_len_i,
    input  op_valid_i, op_a_i, op_b_i,
    input  mac_acc_val_i, mac_acc_i,
    input  res_ready_i,
    output cmd_ready_o, op_ready_o,
    output mac_in1_o, mac_in2_o,
    output mac_valid_o, mac_chunk_end_o,
    output mac_acc_o,
    output res_valid_o, res_dat_o, busy_o
  );

  modport master (
    output cmd_valid_i, cmd_len_i,
    output op_valid_i, op_a_i, op_b_i,
    output mac_acc_val_i, mac_acc_i,
    output res_ready_i,
    input  cmd_ready_o, op_ready_o,
    input  mac_in1_o, mac_in2_o,
    input  mac_valid_o, mac_chunk_end_o,
    input  mac_acc_o,
    input  res_valid_o, res_dat_o, busy_o
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one MAC lane: issues operand pairs,
// retires the MAC's delayed sums and returns the final result.
module mac_seq_ctrl #(
  parameter int DATA_SIZE       = 8,
  parameter int OUTPUT_BUF_SIZE = 32,
  parameter int LEN_W           = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0]           len_q, len_d;
  logic [LEN_W-1:0]           issued_q, issued_d;
  logic [LEN_W-1:0]           retired_q, retired_d;
  logic [OUTPUT_BUF_SIZE-1:0] acc_q, acc_d;

  logic op_ready;
  logic fire;
  logic last_fire;

  assign op_ready  = (state_q == RUN) &&
                     (issued_q < len_q);
  assign fire      = op_ready & bus.op_valid_i;
  assign last_fire = fire &&
    (issued_q == len_q - LEN_W'(1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      acc_q     <= acc_d;
    end
  end

  // Retirement is only honoured while products can be in flight.
  always_comb begin
    len_d     = len_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    acc_d     = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          len_d     = bus.cmd_len_i;
          issued_d  = '0;
          retired_d = '0;
          acc_d     = '0;
        end
      end
      RUN, DRAIN: begin
        if (fire)
          issued_d = issued_q + LEN_W'(1);
        if (bus.mac_acc_val_i) begin
          acc_d     = bus.mac_acc_i;
          retired_d = retired_q + LEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i)
          state_d = (bus.cmd_len_i == '0) ?
                    DONE : RUN;
      end
      RUN: begin
        if (last_fire)
          state_d = DRAIN;
      end
      DRAIN: begin
        // acc_d carries the last sum, so DONE sees it in acc_q
        if (retired_d == len_q)
          state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready_o     = 1'b0;
    bus.op_ready_o      = 1'b0;
    bus.mac_valid_o     = 1'b0;
    bus.mac_in1_o       = '0;
    bus.mac_in2_o       = '0;
    bus.mac_chunk_end_o = 1'b0;
    bus.res_valid_o     = 1'b0;
    bus.res_dat_o       = '0;
    bus.mac_acc_o       = acc_q;
    bus.busy_o          = (state_q != IDLE);
    unique case (state_q)
      IDLE: bus.cmd_ready_o = 1'b1;
      RUN: begin
        bus.op_ready_o      = op_ready;
        bus.mac_valid_o     = fire;
        bus.mac_chunk_end_o = last_fire;
        if (fire) begin
          bus.mac_in1_o = bus.op_a_i;
          bus.mac_in2_o = bus.op_b_i;
        end
      end
      DONE: begin
        bus.res_valid_o = 1'b1;
        bus.res_dat_o   = acc_q;
      end
      default: ;
    endcase
  end

endmodule
